// File: rtl/prog_loader_if.sv
// Byte-stream input and shared IM/DM word-write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_byte, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them
// sequentially to IM/DM, and holds the core in reset until the image is in.
module prog_loader #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    prog_loader_if.slave      bus,
    input  logic              start,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [1:0] {StLoad, StWrite, StDone} state_e;

    localparam logic [ADDR_W-1:0] MaxPtr   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       asm_q, asm_d, word_next;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              last_q, last_d;
    logic              full_q, full_d;   // load ended on capacity, not in_last
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        asm_d     = asm_q;
        ptr_d     = ptr_q;
        wc_d      = wc_q;
        last_d    = last_q;
        full_d    = full_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hold_d    = hold_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        word_next = asm_q;
        word_next[{lane_q, 3'b000} +: 8] = bus.in_byte;

        unique case (state_q)
            StLoad: begin
                if (bus.in_valid) begin
                    asm_d  = word_next;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3 || bus.in_last) begin
                        state_d = StWrite;
                        last_d  = bus.in_last;
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word_next;
                    end
                end
            end
            StWrite: begin
                lane_d = 2'd0;
                asm_d  = 32'd0;
                if (ptr_q != MaxPtr) ptr_d = ptr_q + 1'b1;
                if (wc_q != DepthCnt) wc_d = wc_q + 1'b1;
                if (last_q || ptr_q == MaxPtr) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    full_d  = !last_q;
                end else begin
                    state_d = StLoad;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    wc_d    = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    hold_d  = 1'b1;
                    full_d  = 1'b0;
                    last_d  = 1'b0;
                end else if (full_q && bus.in_valid) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
            lane_q  <= 2'd0;
            asm_q   <= 32'd0;
            ptr_q   <= '0;
            wc_q    <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            ptr_q   <= ptr_d;
            wc_q    <= wc_d;
            last_q  <= last_d;
            full_q  <= full_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StLoad);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign word_count    = wc_q;
endmodule
